// File: rtl/div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl : multi-cycle restoring divider for div.w/div.wu/mod.w/mod.wu
// Rev 1.0
// ---------------------------------------------------------------------------
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_mod,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic        mod_q, mod_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_data_q, res_data_d;

  logic [31:0] dvd_mag, dvs_mag, quot_fix, rem_fix;
  logic [32:0] rem_shift, trial;

  assign dvd_mag   = (sign_q && dvd_q[31]) ? (32'd0 - dvd_q) : dvd_q;
  assign dvs_mag   = (sign_q && dvs_q[31]) ? (32'd0 - dvs_q) : dvs_q;
  // quot_q doubles as the dividend shift register during CALC
  assign rem_shift = {rem_q, quot_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign quot_fix  = q_neg_q ? (32'd0 - quot_q) : quot_q;
  assign rem_fix   = r_neg_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mod_d      = mod_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          sign_d  = req_signed;
          mod_d   = req_mod;
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        q_neg_d = sign_q && (dvd_q[31] ^ dvs_q[31]);
        r_neg_d = sign_q && dvd_q[31];
        cnt_d   = 6'd0;
        rem_d   = 32'd0;
        if (dvs_q == 32'd0) begin
          res_data_d = mod_q ? dvd_q : 32'hFFFF_FFFF;
          state_d    = DONE;
        end else begin
          quot_d  = dvd_mag;
          dvs_d   = dvs_mag;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!trial[32]) begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_shift[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_data_d = mod_q ? rem_fix : quot_fix;
        state_d    = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mod_q      <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 6'd0;
      res_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mod_q      <= mod_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !flush;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// Self-checking bench for div_ctrl: directed and random operations with a result scoreboard.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic        req_mod = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        flush = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_signed(req_signed),
    .req_mod   (req_mod),
    .dividend  (dividend),
    .divisor   (divisor),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .flush     (flush),
    .busy      (busy)
  );

  function automatic logic [31:0] model(input bit sgn, input bit md,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    if (!sgn) return md ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    sr = md ? (sa % sb) : (sa / sb);
    return sr;
  endfunction

  // Starts and ends just after a rising edge with the DUT idle.
  task automatic run_op(input bit sgn, input bit md, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ex,
                        input int lat, input int hold, input string nm);
    int n;
    bit seen;
    logic [31:0] got, d0;
    exp_q.push_back(ex);
    req_valid = 1'b1; req_signed = sgn; req_mod = md; dividend = a; divisor = b;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_signed = $urandom; req_mod = $urandom;
    dividend = $urandom; divisor = $urandom;
    n = 1; seen = 1'b0;
    while (!seen && n <= 100) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    got = exp_q.pop_front();
    n_cmp++;
    if (!seen || n != lat) begin
      n_err++; $display("FAIL %s latency: res_valid in cycle %0d required %0d", nm, n, lat);
    end
    if (seen) begin
      n_cmp++;
      if (res_data !== got) begin
        n_err++; $display("FAIL %s data: got %h required %h", nm, res_data, got);
      end
    end
    d0 = res_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== d0) begin
        n_err++; $display("FAIL %s hold%0d: valid=%b data=%h required 1/%h", nm, i, res_valid, res_data, d0);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid = (hold > 0);
    if (hold > 0) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0) begin
        n_err++; $display("FAIL %s take_ready: req_ready=%b required 0", nm, req_ready);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL %s idle_after: busy=%b res_valid=%b required 0/0", nm, busy, res_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 32'd0) begin
      n_err++; $display("FAIL reset_state: ready=%b valid=%b busy=%b data=%h required 1/0/0/0",
                        req_ready, res_valid, busy, res_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 35, 0, "divwu_100_7");
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 35, 0, "modwu_100_7");
  endtask

  task automatic test_signed();
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 0, "modw_m7_2");
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 0, "divw_m7_2");
  endtask

  task automatic test_overflow();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 0, "divw_min_m1");
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, 0, "modw_min_m1");
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, 0, "divwu_zero");
    run_op(1'b0, 1'b1, 32'h1234, 32'd0, 32'h1234, 2, 0, "modwu_zero");
    run_op(1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 2, 0, "modw_neg_zero");
  endtask

  task automatic test_flush();
    bit rv_seen;
    req_valid = 1'b1; req_signed = 1'b0; req_mod = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_c12: busy=%b req_ready=%b required 1/0", busy, req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_c13: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    rv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid !== 1'b0) rv_seen = 1'b1;
    end
    n_cmp++;
    if (rv_seen) begin
      n_err++; $display("FAIL flush_no_result: res_valid seen=1 required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    bit rv_seen;
    req_valid = 1'b1; req_signed = 1'b1; req_mod = 1'b0; dividend = 32'd999; divisor = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || res_data !== 32'd0) begin
      n_err++; $display("FAIL reset_mid_calc: busy=%b ready=%b data=%h required 0/1/0", busy, req_ready, res_data);
    end
    rv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid !== 1'b0) rv_seen = 1'b1;
    end
    n_cmp++;
    if (rv_seen) begin
      n_err++; $display("FAIL reset_no_result: res_valid seen=1 required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b0, 32'd5000, 32'd13, 32'd384, 35, 5, "backpressure");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit sgn, md;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : $urandom_range(1, 1000));
      if (i == 5) b = 32'hFFFF_FFF0;
      sgn = $urandom; md = $urandom;
      run_op(sgn, md, a, b, model(sgn, md, a, b), (b == 32'd0) ? 2 : 35, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_reset_mid_calc();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
